// File: rtl/rca_subtractor_seq.sv
// Digit-serial a - b (mod 2^DATA_WIDTH) with borrow; result valid DATA_WIDTH/DIGIT_WIDTH cycles after accept.
// in_ready only in IDLE; the result holds in DONE until out_ready, and afterwards until the next result.
module rca_subtractor_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sub_a,
    input  logic [DATA_WIDTH-1:0] in_sub_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_diff_result,
    output logic                  out_borrow
);

    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                digit_cnt_q;
    logic [DATA_WIDTH-1:0]           a_q, b_q, res_q;
    logic                            carry_q;
    logic                            last_digit;
    logic [DIGIT_WIDTH:0]            digit_sum;
    logic [DATA_WIDTH+DIGIT_WIDTH-1:0] res_shift;
    logic [DATA_WIDTH-1:0]           res_next;

    // Operands shift right one digit per cycle, so the low digit is always digit k;
    // result digits enter at the top and land at bits [k*DIGIT_WIDTH +: DIGIT_WIDTH] after the last shift.
    assign digit_sum  = {1'b0, a_q[DIGIT_WIDTH-1:0]} + {1'b0, ~b_q[DIGIT_WIDTH-1:0]}
                      + (DIGIT_WIDTH+1)'(carry_q);
    assign res_shift  = {digit_sum[DIGIT_WIDTH-1:0], res_q};
    assign res_next   = res_shift[DATA_WIDTH+DIGIT_WIDTH-1:DIGIT_WIDTH];
    assign last_digit = (digit_cnt_q == LAST_DIGIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_cnt_q     <= '0;
            a_q             <= '0;
            b_q             <= '0;
            res_q           <= '0;
            carry_q         <= 1'b0;
            out_diff_result <= '0;
            out_borrow      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= in_sub_a;
                        b_q         <= in_sub_b;
                        res_q       <= '0;
                        digit_cnt_q <= '0;
                        carry_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_q         <= a_q >> DIGIT_WIDTH;
                    b_q         <= b_q >> DIGIT_WIDTH;
                    res_q       <= res_next;
                    carry_q     <= digit_sum[DIGIT_WIDTH];
                    digit_cnt_q <= digit_cnt_q + 1'b1;
                    // Outputs only change here, so they hold through DONE and the following IDLE.
                    if (last_digit) begin
                        out_diff_result <= res_next;
                        out_borrow      <= ~digit_sum[DIGIT_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_subtractor_seq.sv
// Scoreboarded bench for rca_subtractor_seq: 32/4 main instance plus 8-bit instances at digit widths 1, 2 and 8.
module tb_rca_subtractor_seq;

    localparam int DW = 32;
    localparam int GW = 4;
    localparam int N  = DW / GW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sub_a, in_sub_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_diff_result;
    logic          out_borrow;

    logic       in_valid8;
    logic [7:0] a8, b8;
    logic [2:0] s_in_ready, s_out_valid, s_borrow;
    logic [7:0] s_diff [3];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [DW-1:0] diff;
        logic          borrow;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    exp_t mon_e;
    int   mon_acc;
    logic ov_prev = 1'b0;

    logic rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_subtractor_seq #(.DATA_WIDTH(DW), .DIGIT_WIDTH(GW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub_a(in_sub_a), .in_sub_b(in_sub_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_diff_result(out_diff_result), .out_borrow(out_borrow)
    );

    function automatic int dw8(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        rca_subtractor_seq #(.DATA_WIDTH(8), .DIGIT_WIDTH((g == 0) ? 1 : ((g == 1) ? 2 : 8))) u8 (
            .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(s_in_ready[g]),
            .in_sub_a(a8), .in_sub_b(b8), .out_valid(s_out_valid[g]),
            .out_ready(1'b1), .out_diff_result(s_diff[g]), .out_borrow(s_borrow[g])
        );
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: latency on out_valid rising, data on each handshake.
    always @(negedge clk) begin
        if (reset) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                total++;
                if (acc_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_valid: out_valid=1 at cycle %0d with nothing outstanding", cyc);
                end else begin
                    mon_acc = acc_q.pop_front();
                    if (cyc - mon_acc != N) begin
                        bad++;
                        $display("FAIL latency: got %0d cycles, expected %0d", cyc - mon_acc, N);
                    end
                end
            end
            if (out_valid && out_ready) begin
                total += 2;
                if (exp_q.size() == 0) begin
                    bad += 2;
                    $display("FAIL result_unexpected: diff=%h borrow=%b with empty scoreboard",
                             out_diff_result, out_borrow);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_diff_result !== mon_e.diff) begin
                        bad++;
                        $display("FAIL diff: got %h expected %h", out_diff_result, mon_e.diff);
                    end
                    if (out_borrow !== mon_e.borrow) begin
                        bad++;
                        $display("FAIL borrow: got %b expected %b (diff exp %h)",
                                 out_borrow, mon_e.borrow, mon_e.diff);
                    end
                end
            end
            ov_prev <= out_valid;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sub_a = a;
        in_sub_b = b;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles", in_ready, guard);
            in_valid = 1'b0;
        end else begin
            e.diff   = a - b;
            e.borrow = (a < b);
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
        end
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        while (exp_q.size() > 0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    int   lat8 [3];
    int   c0;
    logic ov_seen;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sub_a  = '0;
        in_sub_b  = '0;
        in_valid8 = 1'b0;
        a8        = '0;
        b8        = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_diff", 64'(out_diff_result), 64'd0);
        chk("rst_borrow", 64'(out_borrow), 64'd0);
        @(posedge clk);
        #3 reset = 1'b0;

        // Basic subtraction, then back in IDLE with the result held.
        issue(32'h0000000A, 32'h00000003);
        @(negedge clk) in_valid = 1'b0;
        drain(50);
        @(negedge clk);
        chk("idle_after_done", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_hold_diff", 64'(out_diff_result), 64'h7);

        // Wrap-around and equal operands.
        issue(32'h00000000, 32'h00000001);
        @(negedge clk) in_valid = 1'b0;
        drain(50);
        issue(32'h80000000, 32'h80000000);
        @(negedge clk) in_valid = 1'b0;
        drain(50);

        // Hold in DONE with out_ready low, junk in_valid pulses ignored.
        rdy_force = 1'b0;
        issue(32'h12345678, 32'h0FEDCBA9);
        for (int i = 0; i < N + 5; i++) begin
            @(negedge clk);
            in_valid = 1'(i % 2);
            in_sub_a = $urandom;
            in_sub_b = $urandom;
            if (i >= N) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_diff", 64'(out_diff_result), 64'h02468ACF);
            end
        end
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        drain(50);
        @(negedge clk);
        chk("hold_after_idle", 64'(out_diff_result), 64'h02468ACF);
        chk("hold_borrow", 64'(out_borrow), 64'd0);

        // Reset at RUN cycle 3 aborts the operation.
        issue(32'hCAFEF00D, 32'h00001234);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_diff", 64'(out_diff_result), 64'd0);
        chk("abort_borrow", 64'(out_borrow), 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        ov_seen = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        chk("abort_no_valid", 64'(ov_seen), 64'd0);
        issue(32'hDEADBEEF, 32'h12345678);
        @(negedge clk) in_valid = 1'b0;
        drain(50);

        // 8-bit instances: latency 8/DIGIT_WIDTH, 0x05-0x07.
        @(negedge clk);
        chk("sweep_in_ready", 64'(s_in_ready), 64'h7);
        in_valid8 = 1'b1;
        a8 = 8'h05;
        b8 = 8'h07;
        c0 = cyc + 1;
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int g = 0; g < 3; g++) lat8[g] = -1;
        for (int t = 0; t < 20; t++) begin
            for (int g = 0; g < 3; g++)
                if (s_out_valid[g] && lat8[g] < 0) lat8[g] = cyc - c0;
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("sweep_lat_dw%0d", dw8(g)), 64'(lat8[g]), 64'(8 / dw8(g)));
            chk($sformatf("sweep_diff_dw%0d", dw8(g)), 64'(s_diff[g]), 64'hFE);
            chk($sformatf("sweep_borrow_dw%0d", dw8(g)), 64'(s_borrow[g]), 64'd1);
        end

        // Back-to-back random traffic with random out_ready.
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) issue($urandom, $urandom);
        @(negedge clk) in_valid = 1'b0;
        drain(20000);
        rdy_rand = 1'b0;
        chk("latency_queue_empty", 64'(acc_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
